// File: rtl/mem_responder_if.sv
// Load/store handshake bundle between the core (master) and a memory responder (slave).
interface mem_responder_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_strb;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, req_strb, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, req_strb, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/mem_responder.sv
// Data-memory responder: one outstanding load/store, programmable wait states,
// word RAM plus a small MMIO bank (64-bit cycle counter with hi snapshot, scratch).
//
// state  | meaning
// -------+-------------------------------------------------------------
// IDLE   | req_ready=1, waiting for a request
// WAIT   | request latched, wait_cnt counting down the wait states
// EXEC   | one internal cycle: decode, commit write, register response
// RESP   | rsp_valid=1, response held until rsp_ready
//
// RAM_BASE must be aligned to the RAM size and MMIO_BASE to 16 bytes, so the
// decode compares upper address bits and the word index is a plain slice.
// MTIME_INIT only exists so the counter can be started near a wrap point;
// leave it at 0 in normal use.
module mem_responder #(
  parameter int unsigned ADDR_WIDTH  = 10,
  parameter logic [31:0] RAM_BASE    = 32'h8000_0000,
  parameter logic [31:0] MMIO_BASE   = 32'h1000_0000,
  parameter int unsigned WAIT_STATES = 1,
  parameter logic [63:0] MTIME_INIT  = 64'd0
) (
  input logic           clk,
  input logic           reset,
  mem_responder_if.slave bus
);

  localparam logic [3:0] WS = WAIT_STATES[3:0];

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_EXEC, S_RESP} state_t;

  state_t state;
  state_t state_nxt;

  logic [3:0]  wait_cnt;
  logic        we_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [3:0]  strb_q;

  logic [31:0] rdata_q;
  logic        err_q;

  logic [63:0] mtime;
  logic [31:0] mtime_hi_shadow;
  logic [31:0] scratch;

  logic [31:0] ram [0:(1 << ADDR_WIDTH) - 1];

  logic                  accept;
  logic                  exec;
  logic                  ram_hit;
  logic                  mmio_hit;
  logic                  misaligned;
  logic                  exec_err;
  logic [ADDR_WIDTH-1:0] ram_idx;
  logic [31:0]           load_data;

  assign accept     = (state == S_IDLE) && bus.req_valid;
  assign exec       = (state == S_EXEC);
  assign ram_hit    = (addr_q[31:ADDR_WIDTH+2] == RAM_BASE[31:ADDR_WIDTH+2]);
  assign mmio_hit   = (addr_q[31:4] == MMIO_BASE[31:4]);
  assign misaligned = (addr_q[1:0] != 2'b00);
  assign ram_idx    = addr_q[ADDR_WIDTH+1:2];

  // Faults: misaligned, unmapped, or a store to mtime_lo/mtime_hi (offsets 0x0/0x4).
  assign exec_err = misaligned || !(ram_hit || mmio_hit) ||
                    (we_q && mmio_hit && !addr_q[3]);

  // State register; reset abandons any in-flight request or response.
  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic; WAIT is skipped entirely when there are no wait states.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (bus.req_valid) state_nxt = (WS != 4'd0) ? S_WAIT : S_EXEC;
      S_WAIT:  if (wait_cnt == 4'd1) state_nxt = S_EXEC;
      S_EXEC:  state_nxt = S_RESP;
      S_RESP:  if (bus.rsp_ready) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Handshake outputs are pure functions of the state; response data comes from registers.
  always_comb begin
    bus.req_ready = (state == S_IDLE);
    bus.rsp_valid = (state == S_RESP);
    bus.rsp_rdata = rdata_q;
    bus.rsp_err   = err_q;
  end

  // Latch the accepted request and run the wait-state down-counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      strb_q   <= '0;
      wait_cnt <= '0;
    end else if (accept) begin
      we_q     <= bus.req_we;
      addr_q   <= bus.req_addr;
      wdata_q  <= bus.req_wdata;
      strb_q   <= bus.req_strb;
      wait_cnt <= WS;
    end else if (state == S_WAIT) begin
      wait_cnt <= wait_cnt - 4'd1;
    end
  end

  // Read mux for loads; reserved offset 0xC reads as zero.
  always_comb begin
    load_data = '0;
    if (ram_hit) begin
      load_data = ram[ram_idx];
    end else if (mmio_hit) begin
      case (addr_q[3:2])
        2'd0:    load_data = mtime[31:0];
        2'd1:    load_data = mtime_hi_shadow;
        2'd2:    load_data = scratch;
        default: load_data = '0;
      endcase
    end
  end

  // Register the response at EXEC and clear it once the initiator takes it.
  always_ff @(posedge clk) begin
    if (reset) begin
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else if (exec) begin
      err_q   <= exec_err;
      rdata_q <= (exec_err || we_q) ? 32'd0 : load_data;
    end else if ((state == S_RESP) && bus.rsp_ready) begin
      rdata_q <= '0;
      err_q   <= 1'b0;
    end
  end

  // RAM byte-lane writes; a store whose EXEC edge coincides with reset is dropped.
  always_ff @(posedge clk) begin
    if (!reset && exec && we_q && ram_hit && !exec_err) begin
      for (int i = 0; i < 4; i++) begin
        if (strb_q[i]) ram[ram_idx][8*i +: 8] <= wdata_q[8*i +: 8];
      end
    end
  end

  // MMIO side effects: scratch byte writes and the hi-word snapshot on a lo read.
  always_ff @(posedge clk) begin
    if (reset) begin
      scratch         <= '0;
      mtime_hi_shadow <= '0;
    end else if (exec && mmio_hit && !exec_err) begin
      if (we_q && (addr_q[3:2] == 2'd2)) begin
        for (int i = 0; i < 4; i++) begin
          if (strb_q[i]) scratch[8*i +: 8] <= wdata_q[8*i +: 8];
        end
      end
      if (!we_q && (addr_q[3:2] == 2'd0)) mtime_hi_shadow <= mtime[63:32];
    end
  end

  // Free-running 64-bit cycle counter, wraps naturally.
  always_ff @(posedge clk) begin
    if (reset) mtime <= MTIME_INIT;
    else       mtime <= mtime + 64'd1;
  end

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder with WAIT_STATES=1 and mtime started just below a 32-bit wrap.
module tb_mem_responder;
  localparam logic [63:0] MT_INIT = 64'h0000_0000_FFFF_FFE0;
  localparam int          WS      = 1;
  localparam logic [31:0] RAM     = 32'h8000_0000;
  localparam logic [31:0] MMIO    = 32'h1000_0000;

  logic clk = 1'b0;
  logic reset;
  int   errors = 0;
  int   checks = 0;
  logic [63:0] m;

  mem_responder_if bus ();

  mem_responder #(.MTIME_INIT(MT_INIT), .WAIT_STATES(WS)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Reference cycle counter: what mtime should hold at any edge.
  always @(posedge clk) begin
    if (reset) m <= MT_INIT;
    else       m <= m + 64'd1;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic xact(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                      input logic [3:0] strb, output logic [31:0] rdata, output logic err,
                      output int lat, output logic [63:0] mexec);
    int n;
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_we    = we;
    bus.req_addr  = addr;
    bus.req_wdata = wdata;
    bus.req_strb  = strb;
    n = 0;
    while (!bus.req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("accept_ready", {63'd0, bus.req_ready}, 64'd1);
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!bus.rsp_valid && lat < 40);
    rdata = bus.rsp_rdata;
    err   = bus.rsp_err;
    mexec = m - 64'd1;
  endtask

  task automatic xchk(input string tag, input logic we, input logic [31:0] addr,
                      input logic [31:0] wdata, input logic [3:0] strb,
                      input logic [31:0] exp_rdata, input logic exp_err);
    logic [31:0] rd;
    logic        er;
    int          lat;
    logic [63:0] mx;
    xact(we, addr, wdata, strb, rd, er, lat, mx);
    check({tag, "_rdata"}, {32'd0, rd}, {32'd0, exp_rdata});
    check({tag, "_err"}, {63'd0, er}, {63'd0, exp_err});
    check({tag, "_lat"}, 64'(lat), 64'(WS + 2));
  endtask

  task automatic chk_idle_outputs(input string tag);
    check({tag, "_req_ready"}, {63'd0, bus.req_ready}, 64'd1);
    check({tag, "_rsp_valid"}, {63'd0, bus.rsp_valid}, 64'd0);
    check({tag, "_rsp_rdata"}, {32'd0, bus.rsp_rdata}, 64'd0);
    check({tag, "_rsp_err"}, {63'd0, bus.rsp_err}, 64'd0);
  endtask

  initial begin
    logic [31:0] rd;
    logic        er;
    int          lat;
    int          n;
    logic [63:0] mx_lo1;
    logic [63:0] mx_lo2;
    logic [63:0] mx;

    reset         = 1'b1;
    bus.req_valid = 1'b0;
    bus.req_we    = 1'b0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    bus.req_strb  = '0;
    bus.rsp_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_idle_outputs("reset");
    reset = 1'b0;

    // mtime_lo read before the 32-bit wrap, hi read after it returns the snapshot.
    xact(1'b0, MMIO, 32'd0, 4'h0, rd, er, lat, mx_lo1);
    check("mtime_lo1", {32'd0, rd}, {32'd0, mx_lo1[31:0]});
    check("mtime_lo1_err", {63'd0, er}, 64'd0);
    check("mtime_lo1_lat", 64'(lat), 64'(WS + 2));
    n = 0;
    while (m[63:32] == 32'd0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    repeat (10) @(negedge clk);
    xchk("mtime_hi_snap", 1'b0, MMIO + 32'h4, 32'd0, 4'h0, mx_lo1[63:32], 1'b0);
    xact(1'b0, MMIO, 32'd0, 4'h0, rd, er, lat, mx_lo2);
    check("mtime_lo2", {32'd0, rd}, {32'd0, mx_lo2[31:0]});
    xchk("mtime_hi_after", 1'b0, MMIO + 32'h4, 32'd0, 4'h0, mx_lo2[63:32], 1'b0);

    // RAM store/load and byte lanes.
    xchk("st_beef", 1'b1, RAM + 32'h10, 32'hDEAD_BEEF, 4'hF, 32'd0, 1'b0);
    xchk("ld_beef", 1'b0, RAM + 32'h10, 32'd0, 4'h0, 32'hDEAD_BEEF, 1'b0);
    xchk("st_full", 1'b1, RAM + 32'h20, 32'h1122_3344, 4'hF, 32'd0, 1'b0);
    xchk("st_lanes", 1'b1, RAM + 32'h20, 32'hAABB_CCDD, 4'b0101, 32'd0, 1'b0);
    xchk("ld_lanes", 1'b0, RAM + 32'h20, 32'd0, 4'h0, 32'h11BB_33DD, 1'b0);
    xchk("st_last", 1'b1, RAM + 32'hFFC, 32'h5A5A_A5A5, 4'hF, 32'd0, 1'b0);
    xchk("ld_last", 1'b0, RAM + 32'hFFC, 32'd0, 4'h0, 32'h5A5A_A5A5, 1'b0);

    // Faults and no-ops.
    xchk("ld_misalign", 1'b0, RAM + 32'h2, 32'd0, 4'h0, 32'd0, 1'b1);
    xchk("ld_zero", 1'b0, 32'h0000_0000, 32'd0, 4'h0, 32'd0, 1'b1);
    xchk("ld_ram_end", 1'b0, RAM + 32'h1000, 32'd0, 4'h0, 32'd0, 1'b1);
    xchk("st_mtime_lo", 1'b1, MMIO, 32'h0, 4'hF, 32'd0, 1'b1);
    xact(1'b0, MMIO, 32'd0, 4'h0, rd, er, lat, mx);
    check("mtime_after_st", {32'd0, rd}, {32'd0, mx[31:0]});
    xchk("st_mtime_hi", 1'b1, MMIO + 32'h4, 32'h0, 4'hF, 32'd0, 1'b1);
    xchk("st_strb0", 1'b1, RAM + 32'h10, 32'h0, 4'h0, 32'd0, 1'b0);
    xchk("ld_strb0", 1'b0, RAM + 32'h10, 32'd0, 4'h0, 32'hDEAD_BEEF, 1'b0);

    // Scratch and reserved MMIO.
    xchk("ld_scratch0", 1'b0, MMIO + 32'h8, 32'd0, 4'h0, 32'd0, 1'b0);
    xchk("st_scratch", 1'b1, MMIO + 32'h8, 32'hCAFE_F00D, 4'hF, 32'd0, 1'b0);
    xchk("st_scratch_b", 1'b1, MMIO + 32'h8, 32'h1234_5678, 4'b1010, 32'd0, 1'b0);
    xchk("ld_scratch", 1'b0, MMIO + 32'h8, 32'd0, 4'h0, 32'h12FE_560D, 1'b0);
    xchk("st_rsvd", 1'b1, MMIO + 32'hC, 32'hFFFF_FFFF, 4'hF, 32'd0, 1'b0);
    xchk("ld_rsvd", 1'b0, MMIO + 32'hC, 32'd0, 4'h0, 32'd0, 1'b0);

    // Response backpressure: held stable, no new accept until after the handshake.
    @(negedge clk);
    bus.rsp_ready = 1'b0;
    bus.req_valid = 1'b1;
    bus.req_we    = 1'b0;
    bus.req_addr  = RAM + 32'h10;
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    n = 0;
    while (!bus.rsp_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("bp_valid", {63'd0, bus.rsp_valid}, 64'd1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      bus.req_valid = 1'b1;
      bus.req_addr  = RAM + 32'h20;
      check("bp_hold_valid", {63'd0, bus.rsp_valid}, 64'd1);
      check("bp_hold_rdata", {32'd0, bus.rsp_rdata}, 64'hDEAD_BEEF);
      check("bp_req_ready", {63'd0, bus.req_ready}, 64'd0);
    end
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    chk_idle_outputs("bp_release");
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!bus.rsp_valid && lat < 40);
    check("bp_next_rdata", {32'd0, bus.rsp_rdata}, 64'h11BB_33DD);
    check("bp_next_lat", 64'(lat), 64'(WS + 2));

    // Reset during WAIT of a store: old data survives, outputs back to reset values.
    xchk("st_old", 1'b1, RAM + 32'h30, 32'h0000_0001, 4'hF, 32'd0, 1'b0);
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_we    = 1'b1;
    bus.req_addr  = RAM + 32'h30;
    bus.req_wdata = 32'hFFFF_FFFF;
    bus.req_strb  = 4'hF;
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk_idle_outputs("rst_wait");
    reset = 1'b0;
    xchk("ld_after_rst_wait", 1'b0, RAM + 32'h30, 32'd0, 4'h0, 32'h0000_0001, 1'b0);

    // Reset landing on the EXEC edge of a store: write not committed.
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_we    = 1'b1;
    bus.req_addr  = RAM + 32'h30;
    bus.req_wdata = 32'h0000_0002;
    bus.req_strb  = 4'hF;
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk_idle_outputs("rst_exec");
    reset = 1'b0;
    xchk("ld_after_rst_exec", 1'b0, RAM + 32'h30, 32'd0, 4'h0, 32'h0000_0001, 1'b0);
    xchk("scratch_after_rst", 1'b0, MMIO + 32'h8, 32'd0, 4'h0, 32'd0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
